io_unit: RTL and testbench

Responder for the IN/OUT instructions issued by the control decoder. Receives IO_Enable/IO_Selection from the decode stage and serves them. IN stalls the processor until the operator confirms a switch value with a debounced button press, then returns that value for write-back. OUT latches a register value into the display register. Sits between the datapath (register file write-back mux, PC enable) and the board I/O (switches, button, 7-segment/LED driver).

---
 rtl/io_pkg.sv | 20 ++
 rtl/io_debouncer.sv | 44 ++++
 rtl/io_unit.sv | 96 +++++++++
 tb/tb_io_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared encodings for the IN/OUT responder: FSM state codes and the
// decoder's IO_Selection meaning.
package io_pkg;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_WAIT_PRESS   = 2'd1;
  localparam logic [1:0] ST_DONE         = 2'd2;
  localparam logic [1:0] ST_WAIT_RELEASE = 2'd3;

  typedef enum logic [1:0] {
    IDLE         = ST_IDLE,
    WAIT_PRESS   = ST_WAIT_PRESS,
    DONE         = ST_DONE,
    WAIT_RELEASE = ST_WAIT_RELEASE
  } io_state_t;

  localparam logic IO_SEL_IN  = 1'b0;
  localparam logic IO_SEL_OUT = 1'b1;

endpackage

// File: rtl/io_debouncer.sv
// Confirm button conditioning: 2-FF synchronizer, stable-level debouncer and
// rising-edge detect.
module io_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Raw,
  output logic Level,
  output logic Rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] count;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      count  <= '0;
      Level  <= 1'b0;
    end else begin
      sync_1 <= Raw;
      sync_2 <= sync_1;
      if (sync_2 == Level) begin
        count <= '0;
      end else if (count == CNT_LAST) begin
        count <= '0;
        Level <= sync_2;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

  // Rise is high in the cycle whose closing edge raises Level, so a consumer
  // can act on the very edge where the debounced level flips.
  assign Rise = sync_2 & ~Level & (count == CNT_LAST);

endmodule

// File: rtl/io_unit.sv
// Responder for IN/OUT instructions: stalls IN until a debounced confirm press
// captures the switches, latches OUT values into the display register.
//
// state        | meaning
// IDLE         | no IN in progress
// WAIT_PRESS   | IN pending, stalling until a fresh confirm press
// DONE         | switch value captured; write-back cycle, no stall
// WAIT_RELEASE | waiting for the button to be released before the next IN
import io_pkg::*;

module io_unit #(
  parameter int DATA_WIDTH      = 32,
  parameter int SW_WIDTH        = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  IO_Enable,
  input  logic                  IO_Selection,
  input  logic [DATA_WIDTH-1:0] Out_Data,
  input  logic [SW_WIDTH-1:0]   Switches,
  input  logic                  Confirm,
  output logic                  IO_Stall,
  output logic [DATA_WIDTH-1:0] In_Data,
  output logic [DATA_WIDTH-1:0] Display_Data,
  output logic                  Display_Update,
  output logic                  Waiting_Input
);

  io_state_t state;
  io_state_t state_next;
  logic      in_req;
  logic      out_req;
  logic      level;
  logic      press;
  logic      capture;

  assign in_req  = IO_Enable & (IO_Selection == IO_SEL_IN);
  assign out_req = IO_Enable & (IO_Selection == IO_SEL_OUT);

  io_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .Clock(Clock),
    .Reset(Reset),
    .Raw  (Confirm),
    .Level(level),
    .Rise (press)
  );

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    IO_Stall   = 1'b0;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        IO_Stall = in_req;
        if (in_req) state_next = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        IO_Stall = 1'b1;
        if (press) begin
          capture    = 1'b1;
          state_next = DONE;
        end
      end
      DONE: state_next = WAIT_RELEASE;
      WAIT_RELEASE: begin
        // A held button must not satisfy the next IN, so it stalls here too.
        IO_Stall = in_req;
        if (!level) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      In_Data        <= '0;
      Display_Data   <= '0;
      Display_Update <= 1'b0;
    end else begin
      Display_Update <= out_req;
      if (out_req) Display_Data <= Out_Data;
      if (capture) In_Data <= DATA_WIDTH'(Switches);
    end
  end

  assign Waiting_Input = (state == WAIT_PRESS);

endmodule

// File: tb/tb_io_unit.sv
// Directed and randomized bench for io_unit, checked every cycle against a
// behavioural model of the IN/OUT protocol.
module tb_io_unit;

  localparam int DW = 32;
  localparam int SW = 16;
  localparam int D  = 4;

  localparam int PH_IDLE = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_DONE = 2;
  localparam int PH_REL  = 3;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          IO_Enable;
  logic          IO_Selection;
  logic [DW-1:0] Out_Data;
  logic [SW-1:0] Switches;
  logic          Confirm;
  logic          IO_Stall;
  logic [DW-1:0] In_Data;
  logic [DW-1:0] Display_Data;
  logic          Display_Update;
  logic          Waiting_Input;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  io_unit #(
    .DATA_WIDTH     (DW),
    .SW_WIDTH       (SW),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .IO_Enable     (IO_Enable),
    .IO_Selection  (IO_Selection),
    .Out_Data      (Out_Data),
    .Switches      (Switches),
    .Confirm       (Confirm),
    .IO_Stall      (IO_Stall),
    .In_Data       (In_Data),
    .Display_Data  (Display_Data),
    .Display_Update(Display_Update),
    .Waiting_Input (Waiting_Input)
  );

  // Reference model: the button level is accepted once the last D synchronized
  // samples all disagree with it; the protocol is tracked as a phase number.
  bit            raw_q[$];
  bit            synced_q[$];
  bit            m_level;
  int            m_phase;
  logic [DW-1:0] m_in;
  logic [DW-1:0] m_disp;
  bit            m_upd;

  task automatic model_reset();
    raw_q = '{1'b0, 1'b0};
    synced_q.delete();
    m_level = 1'b0;
    m_phase = PH_IDLE;
    m_in    = '0;
    m_disp  = '0;
    m_upd   = 1'b0;
  endtask

  task automatic model_edge();
    bit s;
    bit flip;
    bit in_r;
    bit out_r;
    in_r  = IO_Enable && !IO_Selection;
    out_r = IO_Enable && IO_Selection;
    if (Reset) begin
      model_reset();
      return;
    end
    s = raw_q.pop_front();
    raw_q.push_back(Confirm);
    synced_q.push_back(s);
    if (synced_q.size() > D) void'(synced_q.pop_front());
    flip = (synced_q.size() == D);
    foreach (synced_q[i]) if (synced_q[i] == m_level) flip = 1'b0;
    m_upd = out_r;
    if (out_r) m_disp = Out_Data;
    case (m_phase)
      PH_IDLE: if (in_r) m_phase = PH_WAIT;
      PH_WAIT: if (flip && s) begin
        m_in    = DW'(Switches);
        m_phase = PH_DONE;
      end
      PH_DONE: m_phase = PH_REL;
      default: if (!m_level) m_phase = PH_IDLE;
    endcase
    if (flip) begin
      m_level = s;
      synced_q.delete();
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    bit in_r;
    bit exp_stall;
    #1;
    in_r      = IO_Enable && !IO_Selection;
    exp_stall = (m_phase == PH_IDLE && in_r) || (m_phase == PH_WAIT) ||
                (m_phase == PH_REL && in_r);
    chk("stall",   {31'b0, IO_Stall},       {31'b0, exp_stall});
    chk("waiting", {31'b0, Waiting_Input},  {31'b0, m_phase == PH_WAIT});
    chk("in_data", In_Data,                 m_in);
    chk("display", Display_Data,            m_disp);
    chk("update",  {31'b0, Display_Update}, {31'b0, m_upd});
  endtask

  task automatic tick();
    @(posedge Clock);
    model_edge();
    #1;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      settle();
      tick();
    end
  endtask

  initial begin
    logic [SW-1:0] sw_b;
    int            hold;

    Reset = 1'b1; IO_Enable = 1'b0; IO_Selection = 1'b0;
    Switches = '0; Out_Data = '0; Confirm = 1'b0;
    model_reset();
    tick();

    // Reset with and without an IN request.
    settle();
    chk("rst_stall", {31'b0, IO_Stall}, 32'd0);
    chk("rst_wait",  {31'b0, Waiting_Input}, 32'd0);
    chk("rst_in",    In_Data, 32'd0);
    chk("rst_disp",  Display_Data, 32'd0);
    chk("rst_upd",   {31'b0, Display_Update}, 32'd0);
    tick();
    IO_Enable = 1'b1;
    settle();
    chk("rst_inreq_stall", {31'b0, IO_Stall}, 32'd1);
    tick();
    settle();
    chk("rst_inreq_idle", {31'b0, Waiting_Input}, 32'd0);
    tick();

    // Clean IN of 16'hBEEF.
    Reset = 1'b0; Switches = 16'hBEEF;
    settle();
    chk("clean_req_stall", {31'b0, IO_Stall}, 32'd1);
    tick();
    settle();
    chk("clean_wait", {31'b0, Waiting_Input}, 32'd1);
    Confirm = 1'b1;
    tick();
    repeat (5) begin
      settle();
      chk("clean_hold", {31'b0, IO_Stall}, 32'd1);
      tick();
    end
    settle();
    chk("clean_data",  In_Data, 32'h0000BEEF);
    chk("clean_done",  {31'b0, IO_Stall}, 32'd0);
    tick();
    IO_Enable = 1'b0; Confirm = 1'b0;
    cyc(10);

    // Single-cycle bounces are rejected, then a stable press is accepted.
    sw_b = SW'($urandom); Switches = sw_b; IO_Enable = 1'b1; IO_Selection = 1'b0;
    cyc(1);
    for (int i = 0; i < 4; i++) begin
      Confirm = ((i % 2) == 0);
      settle();
      chk("bounce_stall", {31'b0, IO_Stall}, 32'd1);
      tick();
    end
    Confirm = 1'b0;
    repeat (6) begin
      settle();
      chk("bounce_stall_hold", {31'b0, IO_Stall}, 32'd1);
      chk("bounce_no_cap", In_Data, 32'h0000BEEF);
      tick();
    end
    Confirm = 1'b1;
    cyc(6);
    settle();
    chk("bounce_cap", In_Data, {16'h0, sw_b});
    tick();

    // OUT while the FSM waits for release.
    IO_Selection = 1'b1; Out_Data = 32'h12345678;
    settle();
    chk("out_no_stall", {31'b0, IO_Stall}, 32'd0);
    tick();
    IO_Enable = 1'b0;
    settle();
    chk("out_disp", Display_Data, 32'h12345678);
    chk("out_upd",  {31'b0, Display_Update}, 32'd1);
    tick();
    settle();
    chk("out_upd_pulse", {31'b0, Display_Update}, 32'd0);
    tick();
    Confirm = 1'b0;
    cyc(10);

    // Back-to-back INs with the button held after the first.
    Switches = 16'h0001; IO_Enable = 1'b1; IO_Selection = 1'b0;
    cyc(1);
    Confirm = 1'b1;
    cyc(6);
    settle();
    chk("b2b_first", In_Data, 32'h1);
    tick();
    Switches = 16'h0002;
    repeat (8) begin
      settle();
      chk("b2b_held_stall", {31'b0, IO_Stall}, 32'd1);
      chk("b2b_held_wait",  {31'b0, Waiting_Input}, 32'd0);
      tick();
    end
    Confirm = 1'b0;
    repeat (10) begin
      settle();
      chk("b2b_release_stall", {31'b0, IO_Stall}, 32'd1);
      tick();
    end
    settle();
    chk("b2b_fresh_wait", {31'b0, Waiting_Input}, 32'd1);
    chk("b2b_keep", In_Data, 32'h1);
    Confirm = 1'b1;
    tick();
    cyc(5);
    settle();
    chk("b2b_second", In_Data, 32'h2);
    tick();
    IO_Enable = 1'b0; Confirm = 1'b0;
    cyc(10);

    // Reset while waiting for a press.
    IO_Enable = 1'b1;
    cyc(1);
    settle();
    chk("rmid_wait", {31'b0, Waiting_Input}, 32'd1);
    Confirm = 1'b1;
    tick();
    cyc(1);
    Reset = 1'b1; IO_Enable = 1'b0;
    cyc(1);
    settle();
    chk("rmid_idle",  {31'b0, Waiting_Input}, 32'd0);
    chk("rmid_stall", {31'b0, IO_Stall}, 32'd0);
    chk("rmid_in",    In_Data, 32'd0);
    tick();
    Reset = 1'b0; Confirm = 1'b0;
    cyc(8);

    // Randomized traffic against the model.
    hold = 0;
    for (int n = 0; n < 800; n++) begin
      if (hold == 0) begin
        Confirm = 1'($urandom_range(0, 1));
        hold    = int'($urandom_range(1, 9));
      end else begin
        hold--;
      end
      IO_Enable    = ($urandom_range(0, 2) == 0);
      IO_Selection = 1'($urandom_range(0, 1));
      Switches     = SW'($urandom);
      Out_Data     = DW'($urandom);
      Reset        = ($urandom_range(0, 299) == 0);
      cyc(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
